// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - round-robin write-port scheduler with per-register pending-write scoreboard
module regfile_write_scheduler #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     aluValid,
    input  logic [REG_NUM_WIDTH-1:0] aluNum,
    input  logic [DATA_WIDTH-1:0]    aluData,
    output logic                     aluReady,
    input  logic                     memValid,
    input  logic [REG_NUM_WIDTH-1:0] memNum,
    input  logic [DATA_WIDTH-1:0]    memData,
    output logic                     memReady,
    output logic [DATA_WIDTH-1:0]    wrData,
    output logic [REG_NUM_WIDTH-1:0] wrNum,
    output logic                     regWrite,
    input  logic                     issueValid,
    input  logic [REG_NUM_WIDTH-1:0] issueNum,
    input  logic                     flush,
    input  logic [REG_NUM_WIDTH-1:0] queryNumA,
    input  logic [REG_NUM_WIDTH-1:0] queryNumB,
    output logic                     busyA,
    output logic                     busyB
);

    localparam int REG_COUNT = 1 << REG_NUM_WIDTH;

    // prio: 0 gives the ALU the win on contention, 1 gives the load path the win
    logic                     prio_q, prio_d;
    logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
    logic [REG_NUM_WIDTH-1:0] wr_num_q, wr_num_d;
    logic                     reg_write_q, reg_write_d;
    logic [REG_COUNT-1:0]     busy_q, busy_d;

    logic alu_grant;
    logic mem_grant;

    // Arbitration depends only on valids, the pointer and reset, never on the output stage
    always_comb begin
        alu_grant = rst && aluValid && (!memValid || !prio_q);
        mem_grant = rst && memValid && (!aluValid || prio_q);
    end

    assign aluReady = alu_grant;
    assign memReady = mem_grant;

    // Output stage and priority pointer: load the winner, drop writes aimed at r0
    always_comb begin
        prio_d      = prio_q;
        wr_data_d   = wr_data_q;
        wr_num_d    = wr_num_q;
        reg_write_d = 1'b0;
        if (alu_grant) begin
            prio_d      = 1'b1;
            wr_data_d   = aluData;
            wr_num_d    = aluNum;
            reg_write_d = (aluNum != '0);
        end else if (mem_grant) begin
            prio_d      = 1'b0;
            wr_data_d   = memData;
            wr_num_d    = memNum;
            reg_write_d = (memNum != '0);
        end
    end

    // Scoreboard: commit clears, issue sets (set wins on collision), flush clears everything
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[wr_num_q] = 1'b0;
        end
        if (issueValid && (issueNum != '0)) begin
            busy_d[issueNum] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset discards any write sitting in the output stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q      <= 1'b0;
            wr_data_q   <= '0;
            wr_num_q    <= '0;
            reg_write_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            prio_q      <= prio_d;
            wr_data_q   <= wr_data_d;
            wr_num_q    <= wr_num_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
        end
    end

    assign wrData   = wr_data_q;
    assign wrNum    = wr_num_q;
    assign regWrite = reg_write_q;

    // busy_q[0] is held at zero, so a query of r0 reads back 0
    assign busyA = busy_q[queryNumA];
    assign busyB = busy_q[queryNumB];

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - self-checking bench for regfile_write_scheduler
module tb_regfile_write_scheduler;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int NREG = 1 << RW;

    logic          clk;
    logic          rst;
    logic          aluValid;
    logic [RW-1:0] aluNum;
    logic [DW-1:0] aluData;
    logic          aluReady;
    logic          memValid;
    logic [RW-1:0] memNum;
    logic [DW-1:0] memData;
    logic          memReady;
    logic [DW-1:0] wrData;
    logic [RW-1:0] wrNum;
    logic          regWrite;
    logic          issueValid;
    logic [RW-1:0] issueNum;
    logic          flush;
    logic [RW-1:0] queryNumA;
    logic [RW-1:0] queryNumB;
    logic          busyA;
    logic          busyB;

    int checks = 0;
    int errors = 0;

    regfile_write_scheduler #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RW)) dut (
        .clk(clk), .rst(rst),
        .aluValid(aluValid), .aluNum(aluNum), .aluData(aluData), .aluReady(aluReady),
        .memValid(memValid), .memNum(memNum), .memData(memData), .memReady(memReady),
        .wrData(wrData), .wrNum(wrNum), .regWrite(regWrite),
        .issueValid(issueValid), .issueNum(issueNum), .flush(flush),
        .queryNumA(queryNumA), .queryNumB(queryNumB), .busyA(busyA), .busyB(busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        aluValid = 0; aluNum = '0; aluData = '0;
        memValid = 0; memNum = '0; memData = '0;
        issueValid = 0; issueNum = '0; flush = 0;
        queryNumA = '0; queryNumB = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst = 0;
        aluValid = 1; aluNum = 5'd9; aluData = 32'hCAFE0009;
        memValid = 1; memNum = 5'd10; memData = 32'hBEEF000A;
        issueValid = 1; issueNum = 5'd7; queryNumA = 5'd7;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (aluReady !== 1'b0) begin errors++; $display("FAIL reset_aluReady got %b want 0", aluReady); end
        checks++; if (memReady !== 1'b0) begin errors++; $display("FAIL reset_memReady got %b want 0", memReady); end
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite got %b want 0", regWrite); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL reset_busyA got %b want 0", busyA); end
        checks++; if (wrNum !== '0 || wrData !== '0) begin errors++; $display("FAIL reset_wr got %0d/%h want 0/0", wrNum, wrData); end
        @(negedge clk);
        rst = 1;
        issueValid = 0;
        #1;
        checks++; if (aluReady !== 1'b1 || memReady !== 1'b0) begin errors++; $display("FAIL reset_first_grant got alu %b mem %b want alu 1 mem 0", aluReady, memReady); end
        @(posedge clk);
        #1;
        checks++; if (regWrite !== 1'b1 || wrNum !== 5'd9 || wrData !== 32'hCAFE0009) begin errors++; $display("FAIL reset_first_write got %b %0d %h want 1 9 cafe0009", regWrite, wrNum, wrData); end
        idle_inputs();
    endtask

    task automatic test_single_write();
        apply_reset();
        @(negedge clk);
        aluValid = 1; aluNum = 5'd3; aluData = 32'h12345678;
        #1;
        checks++; if (aluReady !== 1'b1 || memReady !== 1'b0) begin errors++; $display("FAIL single_ready got alu %b mem %b want 1 0", aluReady, memReady); end
        @(posedge clk);
        #1;
        checks++; if (regWrite !== 1'b1 || wrNum !== 5'd3 || wrData !== 32'h12345678) begin errors++; $display("FAIL single_write got %b %0d %h want 1 3 12345678", regWrite, wrNum, wrData); end
        @(negedge clk);
        aluValid = 0;
        @(posedge clk);
        #1;
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", regWrite); end
        checks++; if (wrNum !== 5'd3 || wrData !== 32'h12345678) begin errors++; $display("FAIL single_hold got %0d %h want 3 12345678", wrNum, wrData); end
    endtask

    task automatic test_contention();
        logic [DW-1:0] ad [2];
        logic [DW-1:0] md [2];
        logic [DW-1:0] exp_d;
        logic [RW-1:0] exp_n;
        ad[0] = 32'hA0A0A0A0; ad[1] = 32'hA1A1A1A1;
        md[0] = 32'hD0D0D0D0; md[1] = 32'hD1D1D1D1;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            aluValid = 1; aluNum = RW'(10 + (i + 1) / 2); aluData = ad[(i + 1) / 2];
            memValid = 1; memNum = RW'(20 + i / 2);     memData = md[i / 2];
            exp_d = (i % 2 == 0) ? ad[(i + 1) / 2] : md[i / 2];
            exp_n = (i % 2 == 0) ? RW'(10 + (i + 1) / 2) : RW'(20 + i / 2);
            #1;
            checks++;
            if (aluReady !== (i % 2 == 0) || memReady !== (i % 2 == 1)) begin
                errors++; $display("FAIL contention_grant%0d got alu %b mem %b", i, aluReady, memReady);
            end
            @(posedge clk);
            #1;
            checks++;
            if (regWrite !== 1'b1 || wrNum !== exp_n || wrData !== exp_d) begin
                errors++; $display("FAIL contention_write%0d got %b %0d %h want 1 %0d %h", i, regWrite, wrNum, wrData, exp_n, exp_d);
            end
        end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        apply_reset();
        @(negedge clk);
        issueValid = 1; issueNum = 5'd5; queryNumA = 5'd5;
        #1;
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL sb_c0 got %b want 0", busyA); end
        @(negedge clk);
        issueValid = 0;
        #1;
        checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL sb_c1 got %b want 1", busyA); end
        @(negedge clk);
        @(negedge clk);
        memValid = 1; memNum = 5'd5; memData = 32'h55555555;
        #1;
        checks++; if (memReady !== 1'b1 || busyA !== 1'b1) begin errors++; $display("FAIL sb_c3 got ready %b busy %b want 1 1", memReady, busyA); end
        @(negedge clk);
        memValid = 0; issueValid = 1; issueNum = 5'd5;
        #1;
        checks++; if (regWrite !== 1'b1 || wrNum !== 5'd5 || busyA !== 1'b1) begin errors++; $display("FAIL sb_c4 got wr %b num %0d busy %b want 1 5 1", regWrite, wrNum, busyA); end
        @(negedge clk);
        issueValid = 0;
        #1;
        checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b want 1", busyA); end
        memValid = 1;
        @(negedge clk);
        memValid = 0;
        #1;
        checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL sb_commit_cycle got %b want 1", busyA); end
        @(negedge clk);
        #1;
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL sb_cleared got %b want 0", busyA); end
    endtask

    task automatic test_r0();
        apply_reset();
        @(negedge clk);
        aluValid = 1; aluNum = '0; aluData = 32'hFFFFFFFF;
        issueValid = 1; issueNum = '0; queryNumA = '0; queryNumB = '0;
        #1;
        checks++; if (aluReady !== 1'b1) begin errors++; $display("FAIL r0_ready got %b want 1", aluReady); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL r0_regWrite got %b want 0", regWrite); end
        checks++; if (busyA !== 1'b0 || busyB !== 1'b0) begin errors++; $display("FAIL r0_busy got %b %b want 0 0", busyA, busyB); end
    endtask

    task automatic test_flush();
        apply_reset();
        @(negedge clk);
        issueValid = 1; issueNum = 5'd1;
        @(negedge clk);
        issueNum = 5'd2;
        @(negedge clk);
        issueNum = 5'd4; flush = 1;
        queryNumA = 5'd1; queryNumB = 5'd2;
        aluValid = 1; aluNum = 5'd1; aluData = 32'h0F1F2F3F;
        #1;
        checks++; if (busyA !== 1'b1 || busyB !== 1'b1 || aluReady !== 1'b1) begin errors++; $display("FAIL flush_pre got %b %b %b want 1 1 1", busyA, busyB, aluReady); end
        @(negedge clk);
        idle_inputs();
        queryNumA = 5'd1; queryNumB = 5'd2;
        #1;
        checks++; if (busyA !== 1'b0 || busyB !== 1'b0) begin errors++; $display("FAIL flush_r1r2 got %b %b want 0 0", busyA, busyB); end
        checks++; if (regWrite !== 1'b1 || wrNum !== 5'd1 || wrData !== 32'h0F1F2F3F) begin errors++; $display("FAIL flush_write got %b %0d %h want 1 1 0f1f2f3f", regWrite, wrNum, wrData); end
        queryNumA = 5'd4;
        #1;
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL flush_r4 got %b want 0", busyA); end
    endtask

    task automatic test_random();
        bit            pend [NREG];
        bit            alu_had_last;
        bit            e_rw;
        logic [RW-1:0] e_num;
        logic [DW-1:0] e_data;
        bit            a_hold, m_hold;
        bit            ga, gm;
        apply_reset();
        foreach (pend[r]) pend[r] = 0;
        alu_had_last = 0;
        e_rw = 0; e_num = '0; e_data = '0;
        a_hold = 0; m_hold = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!a_hold) begin
                aluValid = ($urandom_range(0, 9) < 6);
                aluNum = RW'($urandom_range(0, NREG - 1));
                aluData = $urandom;
            end
            if (!m_hold) begin
                memValid = ($urandom_range(0, 9) < 6);
                memNum = RW'($urandom_range(0, NREG - 1));
                memData = $urandom;
            end
            issueValid = ($urandom_range(0, 9) < 3);
            issueNum = RW'($urandom_range(0, NREG - 1));
            flush = ($urandom_range(0, 19) == 0);
            queryNumA = RW'($urandom_range(0, NREG - 1));
            queryNumB = RW'($urandom_range(0, NREG - 1));
            #1;
            // Contention goes to whoever did not win the last contested-or-not grant
            ga = aluValid && (!memValid || !alu_had_last);
            gm = memValid && !ga;
            checks++;
            if (aluReady !== ga || memReady !== gm) begin
                errors++; $display("FAIL rand_ready c%0d got %b %b want %b %b", c, aluReady, memReady, ga, gm);
            end
            checks++;
            if (busyA !== pend[queryNumA] || busyB !== pend[queryNumB]) begin
                errors++; $display("FAIL rand_busy c%0d got %b %b want %b %b", c, busyA, busyB, pend[queryNumA], pend[queryNumB]);
            end
            checks++;
            if (regWrite !== e_rw || (e_rw && (wrNum !== e_num || wrData !== e_data))) begin
                errors++; $display("FAIL rand_write c%0d got %b %0d %h want %b %0d %h", c, regWrite, wrNum, wrData, e_rw, e_num, e_data);
            end
            if (e_rw) pend[e_num] = 0;
            if (issueValid && issueNum != 0) pend[issueNum] = 1;
            if (flush) foreach (pend[r]) pend[r] = 0;
            if (ga) begin
                e_rw = (aluNum != 0); e_num = aluNum; e_data = aluData; alu_had_last = 1;
            end else if (gm) begin
                e_rw = (memNum != 0); e_num = memNum; e_data = memData; alu_had_last = 0;
            end else begin
                e_rw = 0;
            end
            a_hold = aluValid && !ga;
            m_hold = memValid && !gm;
        end
        idle_inputs();
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_scoreboard();
        test_r0();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
